// File: rtl/sign_narrow_32.sv
// Bit-serial signed narrowing of a 32-bit value to 16 or 6 bits.
// Scans from bit 30 down to the target sign bit, then saturates or truncates.
module sign_narrow_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_ovf
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] d_reg, d_next;
  logic        mode_reg, mode_next;
  logic [4:0]  idx_reg, idx_next;
  logic [15:0] data_reg, data_next;
  logic        ovf_reg, ovf_next;

  logic [15:0] fit_data;
  logic [15:0] sat_data;
  logic [4:0]  last_idx;

  // Truncated result; in 6-bit mode bits above 5 replicate bit 5.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_fit
      if (gi < 6) begin : g_low
        assign fit_data[gi] = d_reg[gi];
      end else begin : g_high
        assign fit_data[gi] = mode_reg ? d_reg[5] : d_reg[gi];
      end
    end
  endgenerate

  assign sat_data = d_reg[31] ? (mode_reg ? 16'hFFE0 : 16'h8000)
                              : (mode_reg ? 16'h001F : 16'h7FFF);
  assign last_idx = mode_reg ? 5'd5 : 5'd15;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      d_reg     <= '0;
      mode_reg  <= 1'b0;
      idx_reg   <= '0;
      data_reg  <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      d_reg     <= d_next;
      mode_reg  <= mode_next;
      idx_reg   <= idx_next;
      data_reg  <= data_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    d_next     = d_reg;
    mode_next  = mode_reg;
    idx_next   = idx_reg;
    data_next  = data_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          d_next     = in_data;
          mode_next  = in_mode;
          idx_next   = 5'd30;
          state_next = SCAN;
        end
      end
      SCAN: begin
        if (d_reg[idx_reg] != d_reg[31]) begin
          ovf_next   = 1'b1;
          data_next  = sat_data;
          state_next = DONE;
        end else if (idx_reg == last_idx) begin
          ovf_next   = 1'b0;
          data_next  = fit_data;
          state_next = DONE;
        end else begin
          idx_next = idx_reg - 5'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_data  = data_reg;
  assign out_ovf   = ovf_reg;

endmodule

// File: tb/tb_sign_narrow_32.sv
// Directed bench for sign_narrow_32: latency, narrowed value, overflow flag,
// backpressure and asynchronous reset behaviour.
module tb_sign_narrow_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;

  int errors = 0;
  int checks = 0;

  sign_narrow_32 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  // Issues one request and waits (bounded) for out_valid; leaves the unit in DONE.
  task automatic run_req(input logic [31:0] d, input logic m,
                         output int lat, output logic [15:0] rd, output logic rovf);
    @(negedge clk);
    in_data  = d;
    in_mode  = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    in_mode  = ~m;
    lat = 99;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    rd   = out_data;
    rovf = out_ovf;
  endtask

  task automatic finish_req();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; in_mode = 1'b0;
    #3;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("test_reset: done");
  endtask

  task automatic test_fit16();
    logic [31:0] vd [4] = '{32'h0000_1234, 32'hFFFF_8000, 32'h0000_7FFF, 32'h0000_8000};
    logic [15:0] ed [4] = '{16'h1234, 16'h8000, 16'h7FFF, 16'h7FFF};
    logic        eo [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int lat; logic [15:0] rd; logic ro;
    for (int i = 0; i < 4; i++) begin
      run_req(vd[i], 1'b0, lat, rd, ro);
      checks++; if (lat != 16) begin errors++; $display("FAIL fit16_lat %h: got %0d want 16", vd[i], lat); end
      checks++; if (rd !== ed[i]) begin errors++; $display("FAIL fit16_data %h: got %h want %h", vd[i], rd, ed[i]); end
      checks++; if (ro !== eo[i]) begin errors++; $display("FAIL fit16_ovf %h: got %b want %b", vd[i], ro, eo[i]); end
      $display("fit16: in=%h lat=%0d data=%h ovf=%b", vd[i], lat, rd, ro);
      finish_req();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fit16_idle %h: in_ready got %b want 1", vd[i], in_ready); end
    end
  endtask

  task automatic test_early_exit();
    logic [31:0] vd [3] = '{32'h4000_0000, 32'h0001_0000, 32'h8000_0000};
    int          el [3] = '{1, 15, 1};
    logic [15:0] ed [3] = '{16'h7FFF, 16'h7FFF, 16'h8000};
    int lat; logic [15:0] rd; logic ro;
    for (int i = 0; i < 3; i++) begin
      run_req(vd[i], 1'b0, lat, rd, ro);
      checks++; if (lat != el[i]) begin errors++; $display("FAIL early_lat %h: got %0d want %0d", vd[i], lat, el[i]); end
      checks++; if (rd !== ed[i]) begin errors++; $display("FAIL early_data %h: got %h want %h", vd[i], rd, ed[i]); end
      checks++; if (ro !== 1'b1) begin errors++; $display("FAIL early_ovf %h: got %b want 1", vd[i], ro); end
      $display("early: in=%h lat=%0d data=%h ovf=%b", vd[i], lat, rd, ro);
      finish_req();
    end
  endtask

  task automatic test_mode6();
    logic [31:0] vd [3] = '{32'hFFFF_FFE0, 32'h0000_001F, 32'hFFFF_FFDF};
    logic [15:0] ed [3] = '{16'hFFE0, 16'h001F, 16'hFFE0};
    logic        eo [3] = '{1'b0, 1'b0, 1'b1};
    int lat; logic [15:0] rd; logic ro;
    for (int i = 0; i < 3; i++) begin
      run_req(vd[i], 1'b1, lat, rd, ro);
      checks++; if (lat != 26) begin errors++; $display("FAIL m6_lat %h: got %0d want 26", vd[i], lat); end
      checks++; if (rd !== ed[i]) begin errors++; $display("FAIL m6_data %h: got %h want %h", vd[i], rd, ed[i]); end
      checks++; if (ro !== eo[i]) begin errors++; $display("FAIL m6_ovf %h: got %b want %b", vd[i], ro, eo[i]); end
      $display("mode6: in=%h lat=%0d data=%h ovf=%b", vd[i], lat, rd, ro);
      finish_req();
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [15:0] rd; logic ro;
    run_req(32'hFFFF_FFF5, 1'b1, lat, rd, ro);
    checks++; if (lat != 26) begin errors++; $display("FAIL bp_lat: got %0d want 26", lat); end
    checks++; if (rd !== 16'hFFF5 || ro !== 1'b0) begin errors++; $display("FAIL bp_result: got %h/%b want fff5/0", rd, ro); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = (c % 2 == 0);
      in_data  = 32'h0000_0003;
      in_mode  = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'hFFF5 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold c=%0d: got v=%b d=%h o=%b rdy=%b want 1/fff5/0/0", c, out_valid, out_data, out_ovf, in_ready);
      end
      $display("bp_hold: c=%0d v=%b d=%h o=%b rdy=%b", c, out_valid, out_data, out_ovf, in_ready);
    end
    // Handshake edge with in_valid still high: must not be accepted.
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got rdy=%b v=%b want 1/0", in_ready, out_valid); end
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_accept: in_ready got %b want 1", in_ready); end
    run_req(32'h0000_0040, 1'b1, lat, rd, ro);
    checks++; if (lat != 25) begin errors++; $display("FAIL bp2_lat: got %0d want 25", lat); end
    checks++; if (rd !== 16'h001F || ro !== 1'b1) begin errors++; $display("FAIL bp2_result: got %h/%b want 001f/1", rd, ro); end
    $display("bp2: lat=%0d data=%h ovf=%b", lat, rd, ro);
    finish_req();
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] rd; logic ro;
    @(negedge clk);
    in_data = 32'h0000_1234; in_mode = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int n = 0; n < 5; n++) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0000 || out_ovf !== 1'b0) begin errors++; $display("FAIL rmid_out: got %h/%b want 0000/0", out_data, out_ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    run_req(32'h0000_1234, 1'b0, lat, rd, ro);
    checks++; if (lat != 16) begin errors++; $display("FAIL rmid2_lat: got %0d want 16", lat); end
    checks++; if (rd !== 16'h1234 || ro !== 1'b0) begin errors++; $display("FAIL rmid2_result: got %h/%b want 1234/0", rd, ro); end
    $display("reset_mid: after release lat=%0d data=%h ovf=%b", lat, rd, ro);
    finish_req();
  endtask

  initial begin
    test_reset();
    test_fit16();
    test_early_exit();
    test_mode6();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
